// File: rtl/n0prime_arbiter_if.sv
// Bundle of requester, response and engine signals around the n0prime arbiter.
// The arbiter takes the slave view; the surrounding datapath/bench takes master.
interface n0prime_arbiter_if #(
    parameter int unsigned WIDTH = 2048
);
    logic [1:0]       req;
    logic [WIDTH-1:0] req_p0;
    logic [WIDTH-1:0] req_q0;
    logic [WIDTH-1:0] req_p1;
    logic [WIDTH-1:0] req_q1;
    logic [1:0]       gnt;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_t;
    logic [WIDTH-1:0] rsp_qinv;
    logic             rsp_err;
    logic             busy;
    logic [WIDTH-1:0] eng_p;
    logic [WIDTH-1:0] eng_q;
    logic             eng_start;
    logic [WIDTH-1:0] eng_t;
    logic [WIDTH-1:0] eng_qinv;
    logic             eng_done;

    modport slave (
        input  req, req_p0, req_q0, req_p1, req_q1,
        input  eng_t, eng_qinv, eng_done,
        output gnt, rsp_valid, rsp_t, rsp_qinv, rsp_err, busy,
        output eng_p, eng_q, eng_start
    );

    modport master (
        output req, req_p0, req_q0, req_p1, req_q1,
        output eng_t, eng_qinv, eng_done,
        input  gnt, rsp_valid, rsp_t, rsp_qinv, rsp_err, busy,
        input  eng_p, eng_q, eng_start
    );
endinterface

// File: rtl/n0prime_arbiter.sv
// Round-robin scheduler sharing one n0prime (modular inverse) engine between two
// requesters: screens operands, launches the engine, times out, returns tagged results.
module n0prime_arbiter #(
    parameter int unsigned WIDTH      = 2048,
    parameter int unsigned MAX_CYCLES = 8192
) (
    input  logic                clk,
    input  logic                rst_n,
    n0prime_arbiter_if.slave    bus
);
    localparam int unsigned TW = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             winner_q, winner_d;
    logic             bad_q, bad_d;
    logic             err_q, err_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] qinv_q, qinv_d;

    logic             win;
    logic [WIDTH-1:0] sel_p, sel_q;

    // Requester 1 wins when alone, or on contention when requester 0 was served last.
    assign win   = bus.req[1] & (~bus.req[0] | ~last_q);
    assign sel_p = win ? bus.req_p1 : bus.req_p0;
    assign sel_q = win ? bus.req_q1 : bus.req_q0;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        bad_d    = bad_q;
        err_d    = err_q;
        timer_d  = timer_q;
        p_d      = p_q;
        q_d      = q_q;
        t_d      = t_q;
        qinv_d   = qinv_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    winner_d = win;
                    p_d      = sel_p;
                    q_d      = sel_q;
                    bad_d    = (sel_p == '0) || (sel_p >= sel_q);
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                if (bad_q) begin
                    err_d   = 1'b1;
                    t_d     = '0;
                    qinv_d  = '0;
                    state_d = StResp;
                end else begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Completion takes precedence over a simultaneous timeout.
                if (bus.eng_done) begin
                    t_d     = bus.eng_t;
                    qinv_d  = bus.eng_qinv;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timer_q == TLAST) begin
                    err_d   = 1'b1;
                    t_d     = '0;
                    qinv_d  = '0;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                last_d  = winner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            winner_q <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            p_q      <= '0;
            q_q      <= '0;
            t_q      <= '0;
            qinv_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            p_q      <= p_d;
            q_q      <= q_d;
            t_q      <= t_d;
            qinv_q   <= qinv_d;
        end
    end

    always_comb begin
        bus.gnt       = 2'b00;
        bus.eng_start = 1'b0;
        bus.rsp_valid = 2'b00;
        bus.rsp_err   = 1'b0;
        unique case (state_q)
            StLaunch: begin
                bus.gnt       = {winner_q, ~winner_q};
                bus.eng_start = ~bad_q;
            end
            StResp: begin
                bus.rsp_valid = {winner_q, ~winner_q};
                bus.rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.eng_p    = p_q;
    assign bus.eng_q    = q_q;
    assign bus.rsp_t    = t_q;
    assign bus.rsp_qinv = qinv_q;

endmodule

// File: tb/tb_n0prime_arbiter.sv
// Self-checking bench for n0prime_arbiter: directed scenarios plus randomized
// transactions against a round-robin/latency reference model.
module tb_n0prime_arbiter;
    localparam int unsigned W  = 64;
    localparam int unsigned MC = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    n0prime_arbiter_if #(.WIDTH(W)) bus ();

    n0prime_arbiter #(.WIDTH(W), .MAX_CYCLES(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int start_count = 0;
    int eng_cnt     = 0;
    int eng_lat     = 0;
    logic [W-1:0] eng_rt, eng_rq;

    typedef struct {
        logic [1:0]   gnt;
        int           gnt_n;
        logic         start;
        logic [W-1:0] ep;
        logic [W-1:0] eq;
        logic [1:0]   rv;
        int           rsp_n;
        logic         err;
        logic [W-1:0] t;
        logic [W-1:0] qinv;
        logic [W-1:0] ep_rsp;
        logic         busy_after;
        logic [W-1:0] t_held;
    } obs_t;

    // One clock; also plays the engine: done pulses eng_lat cycles after start (0 = never).
    task automatic step();
        @(posedge clk);
        #1;
        bus.eng_done = 1'b0;
        bus.eng_t    = '0;
        bus.eng_qinv = '0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                bus.eng_done = 1'b1;
                bus.eng_t    = eng_rt;
                bus.eng_qinv = eng_rq;
            end
        end
        if (bus.eng_start) begin
            start_count++;
            if (eng_lat > 0) eng_cnt = eng_lat;
        end
    endtask

    task automatic run_txn(input logic [1:0] r, input logic [W-1:0] p0, input logic [W-1:0] q0,
                           input logic [W-1:0] p1, input logic [W-1:0] q1, input int lat,
                           input logic [W-1:0] rt, input logic [W-1:0] rq, output obs_t o);
        bus.req    = r;
        bus.req_p0 = p0;
        bus.req_q0 = q0;
        bus.req_p1 = p1;
        bus.req_q1 = q1;
        eng_lat    = lat;
        eng_rt     = rt;
        eng_rq     = rq;
        o = '{gnt: 2'b00, gnt_n: -1, start: 1'b0, ep: '0, eq: '0, rv: 2'b00, rsp_n: -1,
              err: 1'b0, t: '0, qinv: '0, ep_rsp: '0, busy_after: 1'b1, t_held: '0};
        for (int n = 1; n <= 60; n++) begin
            step();
            if (bus.gnt != 2'b00 && o.gnt_n < 0) begin
                o.gnt   = bus.gnt;
                o.gnt_n = n;
                o.start = bus.eng_start;
                o.ep    = bus.eng_p;
                o.eq    = bus.eng_q;
                bus.req = bus.req & ~bus.gnt;
            end
            if (bus.rsp_valid != 2'b00) begin
                o.rv     = bus.rsp_valid;
                o.rsp_n  = n;
                o.err    = bus.rsp_err;
                o.t      = bus.rsp_t;
                o.qinv   = bus.rsp_qinv;
                o.ep_rsp = bus.eng_p;
                break;
            end
        end
        step();
        o.busy_after = bus.busy;
        o.t_held     = bus.rsp_t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 2'b00;
        step();
        step();
        checks++; if (bus.gnt !== 2'b00) begin failures++;
            $display("FAIL reset_gnt got=%0h exp=0", bus.gnt); end
        checks++; if (bus.rsp_valid !== 2'b00) begin failures++;
            $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b0) begin failures++;
            $display("FAIL reset_rsp_err got=%0h exp=0", bus.rsp_err); end
        checks++; if (bus.busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.eng_start !== 1'b0) begin failures++;
            $display("FAIL reset_eng_start got=%0h exp=0", bus.eng_start); end
        checks++; if ({bus.eng_p, bus.eng_q} !== '0) begin failures++;
            $display("FAIL reset_eng_pq got=%0h/%0h exp=0", bus.eng_p, bus.eng_q); end
        checks++; if ({bus.rsp_t, bus.rsp_qinv} !== '0) begin failures++;
            $display("FAIL reset_rsp_data got=%0h/%0h exp=0", bus.rsp_t, bus.rsp_qinv); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        obs_t o;
        logic [W-1:0] p, q;
        p = 64'h0000_0001_0000_0000;
        q = 64'h0000_0100_0000_0001;
        run_txn(2'b01, p, q, 64'd7, 64'd9, 10, 64'd5, 64'd7, o);
        checks++; if (o.gnt !== 2'b01 || o.gnt_n != 1) begin failures++;
            $display("FAIL single_gnt got=%0h@%0d exp=1@1", o.gnt, o.gnt_n); end
        checks++; if (o.start !== 1'b1) begin failures++;
            $display("FAIL single_start got=%0h exp=1", o.start); end
        checks++; if (o.ep !== p || o.eq !== q) begin failures++;
            $display("FAIL single_eng_pq got=%0h/%0h exp=%0h/%0h", o.ep, o.eq, p, q); end
        checks++; if (o.rv !== 2'b01 || o.rsp_n != 12) begin failures++;
            $display("FAIL single_rsp got=%0h@%0d exp=1@12", o.rv, o.rsp_n); end
        checks++; if (o.err !== 1'b0 || o.t !== 64'd5 || o.qinv !== 64'd7) begin failures++;
            $display("FAIL single_data got=%0h/%0h/%0h exp=0/5/7", o.err, o.t, o.qinv); end
        checks++; if (o.ep_rsp !== p) begin failures++;
            $display("FAIL single_eng_p_hold got=%0h exp=%0h", o.ep_rsp, p); end
        checks++; if (o.busy_after !== 1'b0 || o.t_held !== 64'd5) begin failures++;
            $display("FAIL single_after got=%0h/%0h exp=0/5", o.busy_after, o.t_held); end
    endtask

    task automatic test_contention();
        obs_t o;
        int s0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        s0 = start_count;
        run_txn(2'b11, 64'd3, 64'd11, 64'd4, 64'd13, 3, 64'h31, 64'h32, o);
        checks++; if (o.gnt !== 2'b01 || o.ep !== 64'd3 || o.eq !== 64'd11) begin failures++;
            $display("FAIL cont_first got=%0h p=%0h q=%0h exp=1 p=3 q=b", o.gnt, o.ep, o.eq); end
        checks++; if (o.rv !== 2'b01 || o.t !== 64'h31) begin failures++;
            $display("FAIL cont_first_rsp got=%0h t=%0h exp=1 t=31", o.rv, o.t); end
        run_txn(bus.req, 64'd3, 64'd11, 64'd4, 64'd13, 4, 64'h41, 64'h42, o);
        checks++; if (o.gnt !== 2'b10 || o.ep !== 64'd4 || o.eq !== 64'd13) begin failures++;
            $display("FAIL cont_second got=%0h p=%0h q=%0h exp=2 p=4 q=d", o.gnt, o.ep, o.eq); end
        checks++; if (o.rv !== 2'b10 || o.qinv !== 64'h42) begin failures++;
            $display("FAIL cont_second_rsp got=%0h qi=%0h exp=2 qi=42", o.rv, o.qinv); end
        checks++; if (start_count - s0 != 2) begin failures++;
            $display("FAIL cont_starts got=%0d exp=2", start_count - s0); end
        bus.req = 2'b00;
    endtask

    task automatic test_fairness();
        obs_t o;
        logic [1:0] exp_g;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            run_txn(2'b11, 64'd5, 64'd6, 64'd8, 64'd9, 2, 64'(100 + i), 64'(200 + i), o);
            checks++; if (o.gnt !== exp_g || o.rv !== exp_g) begin failures++;
                $display("FAIL fair_%0d got=%0h/%0h exp=%0h", i, o.gnt, o.rv, exp_g); end
        end
        bus.req = 2'b00;
    endtask

    task automatic test_reject();
        obs_t o;
        int s0;
        s0 = start_count;
        run_txn(2'b10, 64'd1, 64'd2, 64'd100, 64'd100, 5, 64'h77, 64'h78, o);
        checks++; if (o.gnt !== 2'b10 || o.start !== 1'b0) begin failures++;
            $display("FAIL rej_eq_gnt got=%0h start=%0h exp=2 start=0", o.gnt, o.start); end
        checks++; if (o.rv !== 2'b10 || o.rsp_n != 2 || o.err !== 1'b1) begin failures++;
            $display("FAIL rej_eq_rsp got=%0h@%0d err=%0h exp=2@2 err=1", o.rv, o.rsp_n, o.err); end
        checks++; if (o.t !== '0 || o.qinv !== '0) begin failures++;
            $display("FAIL rej_eq_data got=%0h/%0h exp=0/0", o.t, o.qinv); end
        run_txn(2'b10, 64'd1, 64'd2, 64'd0, 64'd50, 5, 64'h77, 64'h78, o);
        checks++; if (o.rv !== 2'b10 || o.rsp_n != 2 || o.err !== 1'b1) begin failures++;
            $display("FAIL rej_zero_rsp got=%0h@%0d err=%0h exp=2@2 err=1", o.rv, o.rsp_n, o.err); end
        checks++; if (start_count != s0) begin failures++;
            $display("FAIL rej_starts got=%0d exp=%0d", start_count, s0); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(2'b01, 64'd5, 64'd9, 64'd1, 64'd2, 0, 64'h1, 64'h2, o);
        checks++; if (o.rv !== 2'b01 || o.rsp_n != 18 || o.err !== 1'b1) begin failures++;
            $display("FAIL tmo_rsp got=%0h@%0d err=%0h exp=1@18 err=1", o.rv, o.rsp_n, o.err); end
        checks++; if (o.t !== '0 || o.qinv !== '0) begin failures++;
            $display("FAIL tmo_data got=%0h/%0h exp=0/0", o.t, o.qinv); end
        run_txn(2'b01, 64'd5, 64'd9, 64'd1, 64'd2, 16, 64'hAA, 64'hBB, o);
        checks++; if (o.rsp_n != 18 || o.err !== 1'b0) begin failures++;
            $display("FAIL tmo_race got=@%0d err=%0h exp=@18 err=0", o.rsp_n, o.err); end
        checks++; if (o.t !== 64'hAA || o.qinv !== 64'hBB) begin failures++;
            $display("FAIL tmo_race_data got=%0h/%0h exp=aa/bb", o.t, o.qinv); end
    endtask

    task automatic test_reset_midop();
        obs_t o;
        int rv_seen;
        run_txn(2'b01, 64'd2, 64'd3, 64'd1, 64'd2, 2, 64'h55, 64'h66, o);
        checks++; if (o.rv !== 2'b01) begin failures++;
            $display("FAIL mid_pre got=%0h exp=1", o.rv); end
        bus.req    = 2'b10;
        bus.req_p1 = 64'd6;
        bus.req_q1 = 64'd7;
        eng_lat    = 0;
        step();
        step();
        step();
        checks++; if (bus.busy !== 1'b1) begin failures++;
            $display("FAIL mid_busy_before got=%0h exp=1", bus.busy); end
        rst_n   = 1'b0;
        bus.req = 2'b00;
        step();
        rst_n   = 1'b1;
        eng_cnt = 0;
        checks++; if ({bus.busy, bus.gnt, bus.rsp_valid, bus.rsp_err, bus.eng_start} !== '0)
            begin failures++;
            $display("FAIL mid_ctrl got=%0h%0h%0h%0h%0h exp=0", bus.busy, bus.gnt,
                     bus.rsp_valid, bus.rsp_err, bus.eng_start); end
        checks++; if ({bus.eng_p, bus.eng_q, bus.rsp_t, bus.rsp_qinv} !== '0) begin failures++;
            $display("FAIL mid_data got=%0h/%0h/%0h/%0h exp=0", bus.eng_p, bus.eng_q,
                     bus.rsp_t, bus.rsp_qinv); end
        bus.eng_done = 1'b1;
        bus.eng_t    = 64'hFF;
        bus.eng_qinv = 64'hFE;
        rv_seen      = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.rsp_valid != 2'b00 || bus.busy) rv_seen++;
        end
        checks++; if (rv_seen != 0) begin failures++;
            $display("FAIL mid_stray_done got=%0d exp=0", rv_seen); end
        run_txn(2'b11, 64'd8, 64'd9, 64'd6, 64'd7, 3, 64'h12, 64'h34, o);
        checks++; if (o.gnt !== 2'b01 || o.rv !== 2'b01 || o.err !== 1'b0) begin failures++;
            $display("FAIL mid_fresh got=%0h/%0h err=%0h exp=1/1 err=0", o.gnt, o.rv, o.err); end
        checks++; if (o.t !== 64'h12) begin failures++;
            $display("FAIL mid_fresh_t got=%0h exp=12", o.t); end
        bus.req = 2'b00;
    endtask

    task automatic rand_ops(output logic [W-1:0] p, output logic [W-1:0] q);
        logic [W-1:0] a, b;
        int mode;
        a = {$urandom, $urandom} >> 1;
        b = {$urandom, $urandom};
        mode = $urandom_range(0, 5);
        if (mode == 0) begin
            p = '0;
            q = b;
        end else if (mode == 1) begin
            p = a;
            q = a;
        end else if (mode == 2) begin
            p = (a > b) ? a : b;
            q = (a > b) ? b : a;
        end else begin
            p = (a < b) ? a : b;
            q = (a < b) ? b : a;
            if (p == q) q = p + 1;
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic         m_last;
        logic [1:0]   pend, r;
        logic [W-1:0] p [2];
        logic [W-1:0] q [2];
        logic [W-1:0] rt, rq, ep, eq;
        logic         w, bad, err;
        int           lat, exp_n;
        rst_n   = 1'b0;
        bus.req = 2'b00;
        step();
        rst_n   = 1'b1;
        eng_cnt = 0;
        m_last  = 1'b1;
        pend    = 2'b00;
        for (int i = 0; i < 40; i++) begin
            r = pend | 2'($urandom_range(0, 3));
            if (r == 2'b00) r = 2'b01;
            for (int k = 0; k < 2; k++) if (r[k] && !pend[k]) rand_ops(p[k], q[k]);
            lat = $urandom_range(0, 16);
            rt  = {$urandom, $urandom};
            rq  = {$urandom, $urandom};
            w   = (r == 2'b11) ? ~m_last : r[1];
            ep  = p[w];
            eq  = q[w];
            bad = (ep == 0) || (ep >= eq);
            err = bad || (lat == 0);
            exp_n = bad ? 2 : ((lat == 0) ? 2 + MC : 2 + lat);
            run_txn(r, p[0], q[0], p[1], q[1], lat, rt, rq, o);
            checks++; if (o.gnt !== (2'b01 << w) || o.start !== !bad) begin failures++;
                $display("FAIL rnd%0d_gnt got=%0h start=%0h exp=%0h start=%0h", i, o.gnt,
                         o.start, 2'b01 << w, !bad); end
            checks++; if (o.ep !== ep || o.eq !== eq) begin failures++;
                $display("FAIL rnd%0d_ops got=%0h/%0h exp=%0h/%0h", i, o.ep, o.eq, ep, eq); end
            checks++; if (o.rv !== (2'b01 << w) || o.rsp_n != exp_n || o.err !== err) begin
                failures++;
                $display("FAIL rnd%0d_rsp got=%0h@%0d err=%0h exp=%0h@%0d err=%0h", i, o.rv,
                         o.rsp_n, o.err, 2'b01 << w, exp_n, err); end
            checks++; if (o.t !== (err ? '0 : rt) || o.qinv !== (err ? '0 : rq)) begin
                failures++;
                $display("FAIL rnd%0d_data got=%0h/%0h exp=%0h/%0h", i, o.t, o.qinv,
                         err ? '0 : rt, err ? '0 : rq); end
            m_last = w;
            pend   = r & ~(2'b01 << w);
        end
        bus.req = 2'b00;
    endtask

    initial begin
        bus.req      = 2'b00;
        bus.req_p0   = '0;
        bus.req_q0   = '0;
        bus.req_p1   = '0;
        bus.req_q1   = '0;
        bus.eng_t    = '0;
        bus.eng_qinv = '0;
        bus.eng_done = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_reject();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
